// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: bundles the ID-side decoded instruction (the *1 signals),
// the EX-side registered instruction (the *2 signals), the flush request,
// the combinational stall and the event counters of the ID/EX register.
//
//   master : the ID/EX environment (decode drives *1 and Flush, EX consumes *2)
//   slave  : the id_ex_stage itself
interface id_ex_stage_if #(
  parameter int CNT_W = 16
);
  // ID side (decode -> ID/EX)
  logic        JtoPC1, Branch1, RegWrite1, RegDst1;
  logic        ALUSrc1, MemWrite1, MemRead1, MemtoReg1;
  logic [3:0]  ALUOp1;
  logic [31:0] PC4_1, RD1_1, RD2_1, Imm1;
  logic [4:0]  Rs1, Rt1, Rd1;
  logic        Flush;

  // EX side (ID/EX -> execute)
  logic        JtoPC2, Branch2, RegWrite2, RegDst2;
  logic        ALUSrc2, MemWrite2, MemRead2, MemtoReg2;
  logic [3:0]  ALUOp2;
  logic [31:0] PC4_2, RD1_2, RD2_2, Imm2;
  logic [4:0]  Rs2, Rt2, Rd2;

  // hazard / statistics
  logic             Stall;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  modport master (
    output JtoPC1, Branch1, RegWrite1, RegDst1, ALUSrc1, MemWrite1, MemRead1, MemtoReg1,
    output ALUOp1, PC4_1, RD1_1, RD2_1, Imm1, Rs1, Rt1, Rd1, Flush,
    input  JtoPC2, Branch2, RegWrite2, RegDst2, ALUSrc2, MemWrite2, MemRead2, MemtoReg2,
    input  ALUOp2, PC4_2, RD1_2, RD2_2, Imm2, Rs2, Rt2, Rd2,
    input  Stall, StallCnt, FlushCnt
  );

  modport slave (
    input  JtoPC1, Branch1, RegWrite1, RegDst1, ALUSrc1, MemWrite1, MemRead1, MemtoReg1,
    input  ALUOp1, PC4_1, RD1_1, RD2_1, Imm1, Rs1, Rt1, Rd1, Flush,
    output JtoPC2, Branch2, RegWrite2, RegDst2, ALUSrc2, MemWrite2, MemRead2, MemtoReg2,
    output ALUOp2, PC4_2, RD1_2, RD2_2, Imm2, Rs2, Rt2, Rd2,
    output Stall, StallCnt, FlushCnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage MIPS core with
// load-use hazard detection, branch/jump flush and saturating event counters.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (release takes effect at next edge)
//   bus   : id_ex_stage_if.slave
//           *1 inputs   decoded control word, operands, immediate, specifiers
//           Flush       squash the ID instruction (branch/jump resolved in EX)
//           *2 outputs  registered copy presented to EX
//           Stall       combinational hold for PC and IF/ID
//           StallCnt/FlushCnt  saturating counts of stall and flush cycles
//
// Each edge does exactly one of: capture the *1 inputs, or load an all-zero
// noop (bubble). Flush and a load-use hazard both produce a bubble; only a
// hazard without Flush asks upstream to hold, because on a flush IF/ID is
// already refetching the target.
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic       jtopc;
    logic       branch;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic [3:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } data_t;

  ctrl_t ctrl_d, ctrl_q;
  data_t data_d, data_q;

  logic use_rs, use_rt;
  logic rs_match, rt_match;
  logic hazard, stall, bubble;

  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // ---------------------------------------------------------------------------
  // Gather the incoming ID instruction
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl_d            = '0;
    ctrl_d.jtopc      = bus.JtoPC1;
    ctrl_d.branch     = bus.Branch1;
    ctrl_d.reg_write  = bus.RegWrite1;
    ctrl_d.reg_dst    = bus.RegDst1;
    ctrl_d.alu_src    = bus.ALUSrc1;
    ctrl_d.mem_write  = bus.MemWrite1;
    ctrl_d.mem_read   = bus.MemRead1;
    ctrl_d.mem_to_reg = bus.MemtoReg1;
    ctrl_d.alu_op     = bus.ALUOp1;
  end

  always_comb begin
    data_d     = '0;
    data_d.pc4 = bus.PC4_1;
    data_d.rd1 = bus.RD1_1;
    data_d.rd2 = bus.RD2_1;
    data_d.imm = bus.Imm1;
    data_d.rs  = bus.Rs1;
    data_d.rt  = bus.Rt1;
    data_d.rd  = bus.Rd1;
  end

  // ---------------------------------------------------------------------------
  // Load-use hazard detection
  // ---------------------------------------------------------------------------
  // rs is read by any real ALU op except jumps; rt is read by R-type
  // (RegDst), branch compares and stores (store data).
  assign use_rs   = (bus.ALUOp1 != 4'b0000) && !bus.JtoPC1;
  assign use_rt   = bus.RegDst1 | bus.Branch1 | bus.MemWrite1;

  // The load in EX writes its rt; compare against the ID instruction's sources.
  assign rs_match = (data_q.rt == bus.Rs1);
  assign rt_match = (data_q.rt == bus.Rt1);

  // $0 is never a real dependency, so a load to $0 never stalls.
  assign hazard = ctrl_q.mem_read & ctrl_q.reg_write & (data_q.rt != 5'd0) &
                  ((use_rs & rs_match) | (use_rt & rt_match));

  assign stall  = hazard & ~bus.Flush;
  assign bubble = bus.Flush | hazard;

  // ---------------------------------------------------------------------------
  // Pipeline register: capture or bubble. The bubble clears data too so EX
  // sees a clean noop, which also guarantees MemRead2=0 next cycle and thus a
  // hazard never lasts more than one cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else if (bubble) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating event counters, updated on the same edge as the bubble
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (bus.Flush && (flush_cnt != {CNT_W{1'b1}})) begin
      flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.JtoPC2    = ctrl_q.jtopc;
  assign bus.Branch2   = ctrl_q.branch;
  assign bus.RegWrite2 = ctrl_q.reg_write;
  assign bus.RegDst2   = ctrl_q.reg_dst;
  assign bus.ALUSrc2   = ctrl_q.alu_src;
  assign bus.MemWrite2 = ctrl_q.mem_write;
  assign bus.MemRead2  = ctrl_q.mem_read;
  assign bus.MemtoReg2 = ctrl_q.mem_to_reg;
  assign bus.ALUOp2    = ctrl_q.alu_op;

  assign bus.PC4_2     = data_q.pc4;
  assign bus.RD1_2     = data_q.rd1;
  assign bus.RD2_2     = data_q.rd2;
  assign bus.Imm2      = data_q.imm;
  assign bus.Rs2       = data_q.rs;
  assign bus.Rt2       = data_q.rt;
  assign bus.Rd2       = data_q.rd;

  assign bus.Stall     = stall;
  assign bus.StallCnt  = stall_cnt;
  assign bus.FlushCnt  = flush_cnt;

endmodule
